uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Serial UART transmitter consuming the core's byte-stream output (tx_start/tx_data) and driving the board's TX pin.
- Buffers bytes in a small FIFO so core writes never stall.
- Serialises each byte as 8N1 (optionally 8E1) at a fixed baud rate.
- Sits between the CPU core and the top-level UART pin.

Parameters:
CLK_HZ, 24000000, system clock frequency in Hz.
BAUD, 115200, line rate in bits/s; CLKS_PER_BIT = CLK_HZ/BAUD (integer divide, must be >= 2).
FIFO_DEPTH, 16, byte FIFO entries; power of two, >= 2.

Ports:
clock  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous, active-high reset.
tx_start  input  1  write strobe; each cycle high with full=0 enqueues tx_data.
tx_data  input  8  byte to enqueue, sampled when tx_start=1.
tx  output  1  serial line, idle high.
busy  output  1  high while a frame is on the line or the FIFO is non-empty.
full  output  1  FIFO count == FIFO_DEPTH.
overflow  output  1  sticky; set when tx_start=1 while full=1.

Behaviour:
Reset values (next edge with reset=1, overrides everything):
- tx=1, busy=0, full=0, overflow=0.
- FIFO pointers and count = 0; state=IDLE; baud counter=0; bit index=0.

FIFO:
- Circular buffer with wrapping read/write pointers and a count of width log2(FIFO_DEPTH)+1.
- Write when tx_start=1 and count<FIFO_DEPTH.
- Write with count==FIFO_DEPTH is dropped and sets overflow, even if a pop occurs in the same cycle.
- Simultaneous write and pop: count unchanged, both pointers advance.
- full and busy are combinational from registered count/state.

Transmit FSM (one state per frame field):
- IDLE: tx=1. If count>0, pop head into shift register, baud counter=0, go to START. Pop occurs in the cycle the FSM is in IDLE with count>0.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
- DATA: tx = shift[0], LSB first. Each bit is held CLKS_PER_BIT cycles, then shift right and increment bit index. After bit 7, go to PARITY if enabled, else STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.

Timing:
- Baud counter counts 0..CLKS_PER_BIT-1 and resets on each bit boundary.
- Frame length is exactly 10*CLKS_PER_BIT cycles (11 with parity).
- With the FIFO empty and the FSM idle, a write at cycle N gives a pop at N+1, and tx goes low at edge N+2 (registered output).
- Back-to-back frames: IDLE lasts exactly 1 cycle between the stop bit and the next start bit when the FIFO is non-empty.

Boundary conditions:
- Reset asserted mid-frame aborts the frame, flushes the FIFO, and drives tx=1 the next cycle; no partial frame resumes.
- A held tx_start enqueues one byte per cycle until full, with overflow set on every subsequent held cycle.
- busy=1 from the cycle after the first accepted write until STOP completes with the FIFO empty.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP. It drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame = 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state, no parity logic, DATA goes directly to STOP. Frame = 10*CLKS_PER_BIT cycles.

Test Plan:
All scenarios use CLK_HZ=1000, BAUD=100, so CLKS_PER_BIT=10.
1. Single byte: reset, then one-cycle write of 0xA5 at cycle N -> tx low at N+2 for 10 cycles; then bits 1,0,1,0,0,1,0,1 at 10 cycles each; then high for 10 cycles. busy drops after the stop bit.
2. Back-to-back: write 0x00, 0xFF, 0x55 on consecutive cycles -> three contiguous frames, each 100 cycles, separated by one idle cycle; decoded bytes match in order.
3. Overflow: hold tx_start=1 for 20 cycles with FIFO_DEPTH=16 -> full asserts once the FIFO holds 16 bytes, overflow set and stays set, and exactly 17 frames are sent (one popped during the fill, 16 buffered).
4. Simultaneous write and pop at count==FIFO_DEPTH -> write dropped, overflow=1, count becomes FIFO_DEPTH-1.
5. Reset mid-frame: assert reset during data bit 3 of 0x3C with 4 bytes queued -> tx=1, busy=0, full=0 next cycle; no further frames appear.
6. With UART_TX_PARITY_EN defined: send 0x07 -> parity bit 1, frame 110 cycles; send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-FIFO-buffered UART transmitter (8N1, or 8E1 when
// UART_TX_PARITY_EN is defined).
//
// Parameters:
//   CLK_HZ     system clock frequency in Hz
//   BAUD       line rate; CLKS_PER_BIT = CLK_HZ/BAUD (must be >= 2)
//   FIFO_DEPTH byte FIFO entries (power of two, >= 2)
//
// Ports:
//   clock     system clock, rising edge
//   reset     synchronous active-high reset
//   tx_start  write strobe; enqueues tx_data when the FIFO is not full
//   tx_data   byte to enqueue
//   tx        serial line, idle high (registered)
//   busy      frame in progress or FIFO non-empty
//   full      FIFO holds FIFO_DEPTH bytes
//   overflow  sticky; a write was attempted while full
//
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit
// between the data bits and the stop bit.
module uart_tx_fifo #(
  parameter int CLK_HZ     = 24000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       overflow
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int CNTW         = AW + 1;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] DEPTH_CNT = CNTW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CNTW-1:0] count;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
`ifdef UART_TX_PARITY_EN
  logic            parity_bit;
`endif

  logic write;
  logic pop;
  logic baud_end;

  assign full     = (count == DEPTH_CNT);
  assign busy     = (state != IDLE) || (count != '0);
  assign write    = tx_start && !full;
  assign pop      = (state == IDLE) && (count != '0);
  assign baud_end = (baud_cnt == BAUD_LAST);

  // Storage is not reset: the pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (write) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // A write while full is dropped even if a pop happens in the same cycle,
  // because acceptance is decided from the registered count.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (write && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !write) begin
        count <= count - 1'b1;
      end
      if (tx_start && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // tx is registered from the current state, so the line trails the state
  // by one cycle; every field still lasts exactly CLKS_PER_BIT cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      tx         <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift      <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^mem[rd_ptr];
`endif
            baud_cnt   <= '0;
            state      <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          tx <= shift[0];
          if (baud_end) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx <= parity_bit;
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          tx <= 1'b1;
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo at CLK_HZ=1000, BAUD=100 (10 clocks per bit).
module tb_uart_tx_fifo;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx;
  logic       busy;
  logic       full;
  logic       overflow;

  uart_tx_fifo #(
    .CLK_HZ(1000),
    .BAUD(100),
    .FIFO_DEPTH(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx(tx),
    .busy(busy),
    .full(full),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    logic       par;
    logic [7:0] data;
  } sb_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  sb_t  sb[$];
  int   checks = 0;
  int   failures = 0;
  int   frames = 0;
  logic chk_gap = 1'b0;
  int   gap_epoch = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic sb_t mk(input logic [7:0] d, input logic p);
    sb_t e;
    e.data = d;
    e.par  = p;
    return e;
  endfunction

  function automatic logic [10:0] exp_frame(input sb_t e);
`ifdef UART_TX_PARITY_EN
    return {1'b1, e.par, e.data, 1'b0};
`else
    return {1'b0, 1'b1, e.data, 1'b0};
`endif
  endfunction

  task automatic drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while ((busy !== 1'b0 || sb.size() != 0) && n < max_cyc) begin
      @(negedge clock);
      n++;
    end
    check(name, (n >= max_cyc), 0);
    repeat (2) @(negedge clock);
  endtask

  // Line monitor: decodes each frame sample by sample and scores it.
  initial begin : monitor
    logic [10:0] bits;
    logic        glitch;
    logic        abort;
    int          st;
    int          prev_st;
    logic        prev_valid;
    int          prev_epoch;
    sb_t         e;
    prev_st    = 0;
    prev_valid = 1'b0;
    prev_epoch = 0;
    forever begin
      @(negedge clock);
      if (reset === 1'b0 && tx === 1'b0) begin
        st     = cyc;
        bits   = '0;
        glitch = 1'b0;
        abort  = 1'b0;
        for (int b = 0; b < NB; b++) begin
          for (int s = 0; s < CPB; s++) begin
            if (b != 0 || s != 0) @(negedge clock);
            if (reset !== 1'b0) abort = 1'b1;
            if (s == 0) bits[b] = tx;
            else if (tx !== bits[b]) glitch = 1'b1;
          end
        end
        if (!abort) begin
          frames++;
          if (chk_gap && prev_valid && prev_epoch == gap_epoch)
            check("frame_gap", st - prev_st, FRAME + 1);
          prev_valid = chk_gap;
          prev_epoch = gap_epoch;
          prev_st    = st;
          check("bit_timing", glitch, 0);
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame actual=%0h required=none (cycle %0d)", bits, cyc);
          end else begin
            e = sb.pop_front();
            check("frame_bits", bits, exp_frame(e));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vec_t       vecs[8];
    logic [7:0] b2b[3];
    int         c0;
    int         n;
    int         f0;
    int         lows;

    vecs[0] = '{data: 8'hA5, par: 1'b0};
    vecs[1] = '{data: 8'h07, par: 1'b1};
    vecs[2] = '{data: 8'h03, par: 1'b0};
    vecs[3] = '{data: 8'h3C, par: 1'b0};
    vecs[4] = '{data: 8'h00, par: 1'b0};
    vecs[5] = '{data: 8'hFF, par: 1'b0};
    vecs[6] = '{data: 8'h01, par: 1'b1};
    vecs[7] = '{data: 8'h80, par: 1'b1};
    b2b[0] = 8'h00;
    b2b[1] = 8'hFF;
    b2b[2] = 8'h55;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_full", full, 0);
    check("reset_overflow", overflow, 0);
    reset = 1'b0;

    // Single bytes from idle: latency, frame contents, busy window
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      #1;
      c0       = cyc;
      tx_start = 1'b1;
      tx_data  = vecs[i].data;
      sb.push_back(mk(vecs[i].data, vecs[i].par));
      @(posedge clock);
      #1;
      tx_start = 1'b0;
      check("busy_after_write", busy, 1);
      n = 0;
      while (tx !== 1'b0 && n < 20) begin
        @(negedge clock);
        n++;
      end
      check("start_latency", cyc - c0, 3);
      n = 0;
      while (busy !== 1'b0 && n < FRAME + 20) begin
        @(negedge clock);
        n++;
      end
      check("busy_drop", cyc - c0, FRAME + 2);
      drain("drain_single", FRAME + 20);
    end
    check("no_overflow_single", overflow, 0);

    // Back-to-back writes: contiguous frames with one idle cycle between
    f0 = frames;
    gap_epoch++;
    chk_gap = 1'b1;
    @(posedge clock);
    #1;
    tx_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_data = b2b[i];
      sb.push_back(mk(b2b[i], ^b2b[i]));
      @(posedge clock);
      #1;
    end
    tx_start = 1'b0;
    drain("drain_b2b", 4 * FRAME);
    check("b2b_frames", frames - f0, 3);
    chk_gap = 1'b0;

    // Held write for 20 cycles: 17 accepted, then full and sticky overflow
    f0 = frames;
    gap_epoch++;
    chk_gap = 1'b1;
    @(posedge clock);
    #1;
    tx_start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tx_data = 8'h80 + 8'(i);
      if (i < 17) sb.push_back(mk(tx_data, ^tx_data));
      @(posedge clock);
      #1;
      if (i == 15) begin
        check("full_at_15", full, 0);
        check("ovf_at_15", overflow, 0);
      end
      if (i == 16) begin
        check("full_at_16", full, 1);
        check("ovf_at_16", overflow, 0);
      end
      if (i == 17) check("ovf_at_17", overflow, 1);
    end
    tx_start = 1'b0;
    check("ovf_sticky", overflow, 1);

    // Write in the same cycle as the second pop while full: dropped
    repeat (FRAME + 2 - 20) @(posedge clock);
    #1;
    check("full_before_pop", full, 1);
    tx_start = 1'b1;
    tx_data  = 8'hEE;
    @(posedge clock);
    #1;
    check("full_after_pop_drop", full, 0);
    check("ovf_after_pop_drop", overflow, 1);
    tx_data = 8'h77;
    sb.push_back(mk(8'h77, ^tx_data));
    @(posedge clock);
    #1;
    check("refill_to_full", full, 1);
    tx_data = 8'h66;
    @(posedge clock);
    #1;
    tx_start = 1'b0;
    check("still_full", full, 1);
    drain("drain_overflow", 20 * (FRAME + 1) + 100);
    check("overflow_frames", frames - f0, 18);
    chk_gap = 1'b0;

    // Reset during data bit 3 of 0x3C with four more bytes queued
    f0 = frames;
    @(posedge clock);
    #1;
    tx_start = 1'b1;
    tx_data  = 8'h3C;
    @(posedge clock);
    #1;
    tx_data = 8'h11;
    @(posedge clock);
    #1;
    tx_data = 8'h22;
    @(posedge clock);
    #1;
    tx_data = 8'h33;
    @(posedge clock);
    #1;
    tx_data = 8'h44;
    @(posedge clock);
    #1;
    tx_start = 1'b0;
    check("full_before_reset", full, 0);
    repeat (40) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("midreset_tx", tx, 1);
    check("midreset_busy", busy, 0);
    check("midreset_full", full, 0);
    check("midreset_overflow", overflow, 0);
    reset = 1'b0;
    lows = 0;
    repeat (4 * FRAME) begin
      @(negedge clock);
      if (tx !== 1'b1) lows++;
    end
    check("no_line_activity_after_reset", lows, 0);
    check("no_frames_after_reset", frames - f0, 0);
    check("busy_after_reset", busy, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
